wb_mem: RTL and testbench
=========================

# wb_mem

Pipelined Wishbone B4 read/write responder backed by a single-port word RAM. It is the far end of the instruction-fetch bus: FETCH (or any Wishbone master in the design) issues pipelined requests, and this block acknowledges each one after a fixed latency. It serves as the program/data memory in system builds and as the bus model in FETCH benches. Optionally, it injects bounded pseudo-random stalls to exercise master flow control.

## Interface
- G_ADDR_SIZE, 8: address bits actually decoded; memory depth 2**G_ADDR_SIZE words; upper wb_addr_i bits ignored.
- G_DATA_SIZE, 16: word width.
- G_LATENCY, 2: cycles from request accept to ack; legal range 1..4.

Ports:
- clk_i, in, 1: single clock, all logic on rising edge.
- rst_i, in, 1: synchronous, active-high reset.
- wb_cyc_i, in, 1: bus cycle active.
- wb_stb_i, in, 1: request strobe.
- wb_stall_o, out, 1: request not accepted this cycle.
- wb_we_i, in, 1: 1 = write, 0 = read.
- wb_addr_i, in, 16: word address.
- wb_data_i, in, G_DATA_SIZE: write data.
- wb_ack_o, out, 1: response valid.
- wb_data_o, out, G_DATA_SIZE: read data; valid only with wb_ack_o on a read response.

## Operation
- Accept condition: wb_cyc_i & wb_stb_i & !wb_stall_o. One request is accepted per accepting cycle.
- Write: RAM[addr] <= wb_data_i at the accepting edge.
- Read: RAM[addr] is sampled at the accepting edge, before any same-edge write. Read-after-write in consecutive accepted requests returns the new data.
- Each accept enters a G_LATENCY-deep shift pipeline (valid bit, read data). Writes carry don't-care data. Stages do not stall, so up to G_LATENCY requests are outstanding.
- wb_ack_o = last-stage valid & wb_cyc_i (combinational gate). An ack never appears with cyc low.
- Power-up RAM contents: word at address a = ~a (bitwise NOT, truncated to G_DATA_SIZE). Only writes and configuration change RAM; reset never does.
- wb_cyc_i low at an edge: all pipeline valid bits are cleared, so outstanding responses are dropped. No request is accepted.
- Acks come out strictly in request order, exactly one per accepted request unless flushed.
- Data output register is not cleared between responses. Masters must qualify wb_data_o with wb_ack_o.

## Timing
- Request accepted at edge N; wb_ack_o high in the cycle following edge N+G_LATENCY-1. For G_LATENCY=1, ack is in the cycle right after accept.
- Back-to-back accepts produce back-to-back acks at full throughput.
- Reset values: wb_ack_o=0, wb_stall_o=0, pipeline valid all 0, wb_data_o=0, stall LFSR=0xACE1, stall run counter=0.
- rst_i asserted mid-transfer: the pipeline is flushed at that edge and no ack is produced for pending requests. The RAM write of a request accepted on the same cycle as rst_i is suppressed.
- Simultaneous cyc drop and last-stage valid: no ack (gated); valid is cleared.
- Address wrap: addresses ≥ 2**G_ADDR_SIZE alias modulo depth.

## Configuration
- WB_MEM_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - wb_stall_o is registered and goes high when lfsr[1:0]==2'b00.
  - A run counter forces wb_stall_o low after 3 consecutive stall cycles, so a stall never exceeds 3 cycles.
  - Stall is independent of cyc/stb.
- WB_MEM_STALL_EN undefined: wb_stall_o tied 0, and the LFSR and counter are not built.

## Test plan
- Reset, then with G_LATENCY=2 read addr 0x0005 once → wb_ack_o high exactly 2 cycles after accept, wb_data_o=0xFFFA.
- Four back-to-back reads 0x0010..0x0013 → four consecutive ack cycles with data 0xFFEF, 0xFFEE, 0xFFED, 0xFFEC in order.
- Write 0x1234 to 0x0020, next cycle read 0x0020 → write ack, then read ack with data 0x1234. A later read of 0x0120 (G_ADDR_SIZE=8) also returns 0x1234.
- Issue 2 reads, drop wb_cyc_i the cycle after the second accept → no acks observed. A new cycle's read of 0x0001 returns 0xFFFE with correct latency.
- Assert rst_i with 2 reads outstanding → wb_ack_o stays 0 until a new request completes. RAM contents written before reset persist.
- With WB_MEM_STALL_EN: 1000 cycles of continuous stb →
  - no stall run longer than 3;
  - acks equal accepted count;
  - every ack data = ~address.

Source files
------------

// File: rtl/wb_mem.sv
// -----------------------------------------------------------------------------
// wb_mem -- pipelined Wishbone B4 read/write responder backed by a word RAM.
//
// Every accepted request (wb_cyc_i & wb_stb_i & !wb_stall_o) travels down a
// fixed G_LATENCY-deep pipeline and is acknowledged at its far end, in request
// order, at full throughput. Reads sample the RAM at the accepting edge; writes
// commit at the accepting edge. The RAM powers up holding ~address in each word
// and is never touched by reset.
//
// Optional build macro: WB_MEM_STALL_EN
//   defined   -> a 16-bit LFSR drives registered pseudo-random stalls, with no
//                stall run longer than 3 cycles.
//   undefined -> wb_stall_o is tied low.
//
// Parameters:
//   G_ADDR_SIZE  decoded address bits (depth 2**G_ADDR_SIZE words)
//   G_DATA_SIZE  word width
//   G_LATENCY    accept-to-ack latency in cycles, 1..4
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   wb_cyc_i    bus cycle active; low flushes outstanding responses
//   wb_stb_i    request strobe
//   wb_stall_o  request not accepted this cycle
//   wb_we_i     1 = write, 0 = read
//   wb_addr_i   word address (upper bits alias)
//   wb_data_i   write data
//   wb_ack_o    response valid (gated by wb_cyc_i)
//   wb_data_o   read data, qualified by wb_ack_o
// -----------------------------------------------------------------------------
module wb_mem #(
    parameter int G_ADDR_SIZE = 8,
    parameter int G_DATA_SIZE = 16,
    parameter int G_LATENCY   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic                   wb_stall_o,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_addr_i,
    input  logic [G_DATA_SIZE-1:0] wb_data_i,
    output logic                   wb_ack_o,
    output logic [G_DATA_SIZE-1:0] wb_data_o
);

    localparam int DEPTH = 2 ** G_ADDR_SIZE;

    typedef logic [DEPTH-1:0][G_DATA_SIZE-1:0] mem_t;

    // Power-up image: each word holds the bitwise NOT of its own address.
    function automatic mem_t mem_init_f();
        mem_t m;
        for (int a = 0; a < DEPTH; a++) begin
            m[a] = ~G_DATA_SIZE'(a);
        end
        return m;
    endfunction

    mem_t                      mem_r = mem_init_f();
    logic [G_LATENCY-1:0]      valid_r;
    logic [G_DATA_SIZE-1:0]    data_r [G_LATENCY];
    logic [G_ADDR_SIZE-1:0]    addr_s;
    logic                      accept_s;
    logic                      unused_addr_s;

    // Upper address bits alias; they are intentionally ignored.
    assign addr_s        = wb_addr_i[G_ADDR_SIZE-1:0];
    assign unused_addr_s = ^wb_addr_i;

    assign accept_s  = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign wb_ack_o  = valid_r[G_LATENCY-1] & wb_cyc_i;
    assign wb_data_o = data_r[G_LATENCY-1];

    // RAM write port; a write accepted together with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_r <= mem_r;
        end else if (accept_s && wb_we_i) begin
            mem_r[addr_s] <= wb_data_i;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Response valid pipeline; a low cyc drops every outstanding response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= '0;
        end else if (!wb_cyc_i) begin
            valid_r <= '0;
        end else begin
            valid_r[0] <= accept_s;
            for (int i = 1; i < G_LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Read data pipeline; sampled before the same-edge write lands, never
    // cleared between responses (writes carry whatever word was addressed).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < G_LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            data_r[0] <= mem_r[addr_s];
            for (int i = 1; i < G_LATENCY; i++) begin
                data_r[i] <= data_r[i-1];
            end
        end
    end

`ifdef WB_MEM_STALL_EN
    logic [15:0] lfsr_r;
    logic [1:0]  run_r;
    logic        stall_r;
    logic        fb_s;
    logic        stall_s;
    logic [1:0]  run_s;

    assign wb_stall_o = stall_r;

    // Stall decision: stall when lfsr[1:0] is zero, but never a 4th cycle in a row.
    always_comb begin
        fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        stall_s = 1'b0;
        run_s   = 2'd0;
        if ((lfsr_r[1:0] == 2'b00) && (run_r != 2'd3)) begin
            stall_s = 1'b1;
            run_s   = run_r + 2'd1;
        end else begin
            stall_s = 1'b0;
            run_s   = 2'd0;
        end
    end

    // LFSR, stall run counter and registered stall output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r  <= 16'hACE1;
            run_r   <= 2'd0;
            stall_r <= 1'b0;
        end else begin
            lfsr_r  <= {lfsr_r[14:0], fb_s};
            run_r   <= run_s;
            stall_r <= stall_s;
        end
    end
`else
    assign wb_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem.sv
module tb_wb_mem;

    localparam int L = 2;

    logic        clk_i;
    logic        rst_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_stall_o;
    logic        wb_we_i;
    logic [15:0] wb_addr_i;
    logic [15:0] wb_data_i;
    logic        wb_ack_o;
    logic [15:0] wb_data_o;

    typedef struct {
        logic        we;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] got_q[$];
    logic [15:0] model_mem [256];
    int          total;
    int          bad;
    int          cyc_cnt;
    int          ack_cnt;
    int          n0;

`ifdef WB_MEM_STALL_EN
    int acc_n;
    int run_len;
    int max_run;
    int stall_n;
`endif

    wb_mem #(
        .G_ADDR_SIZE(8),
        .G_DATA_SIZE(16),
        .G_LATENCY  (L)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_stall_o(wb_stall_o),
        .wb_we_i   (wb_we_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .wb_ack_o  (wb_ack_o),
        .wb_data_o (wb_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        exp_t e;
        if (wb_cyc_i) begin
            if (wb_ack_o) begin
                ack_cnt++;
                got_q.push_back(wb_data_o);
                chk("ack_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("ack_latency", cyc_cnt, e.due);
                    if (!e.we) begin
                        chk("ack_data", 32'(wb_data_o), 32'(e.data));
                    end
                end
            end else if (sb_q.size() != 0) begin
                chk("ack_missing", 32'(sb_q[0].due > cyc_cnt), 32'd1);
                if (sb_q[0].due <= cyc_cnt) begin
                    void'(sb_q.pop_front());
                end
            end
        end else begin
            chk("ack_with_cyc_low", 32'(wb_ack_o), 32'd0);
        end
        if (rst_i || !wb_cyc_i) begin
            sb_q.delete();
        end else if (wb_stb_i && !wb_stall_o) begin
            e.we   = wb_we_i;
            e.data = model_mem[wb_addr_i[7:0]];
            e.due  = cyc_cnt + L;
            sb_q.push_back(e);
            if (wb_we_i) begin
                model_mem[wb_addr_i[7:0]] = wb_data_i;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] data);
        logic acc;
        acc       = 1'b0;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = addr;
        wb_data_i = data;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk_i);
            acc = !wb_stall_o;
            @(posedge clk_i);
            #1;
        end
        wb_stb_i = 1'b0;
        chk("req_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; cyc_cnt = 0; ack_cnt = 0;
        for (int a = 0; a < 256; a++) model_mem[a] = ~16'(a);
        rst_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = 16'h0000; wb_data_i = 16'h0000;

        // Reset state
        idle(3);
        chk("reset_ack", 32'(wb_ack_o), 32'd0);
        chk("reset_stall", 32'(wb_stall_o), 32'd0);
        chk("reset_data", 32'(wb_data_o), 32'h0000);
        rst_i = 1'b0;
        idle(1);

        // Single read
        got_q.delete();
        do_req(1'b0, 16'h0005, 16'h0000);
        wait_idle();
        chk("single_read_cnt", got_q.size(), 32'd1);
        chk("single_read_data", 32'(got_q[0]), 32'h0000FFFA);

        // Four back-to-back reads
        got_q.delete();
        for (int i = 0; i < 4; i++) do_req(1'b0, 16'h0010 + 16'(i), 16'h0000);
        wait_idle();
        chk("burst_cnt", got_q.size(), 32'd4);
        chk("burst_d0", 32'(got_q[0]), 32'h0000FFEF);
        chk("burst_d1", 32'(got_q[1]), 32'h0000FFEE);
        chk("burst_d2", 32'(got_q[2]), 32'h0000FFED);
        chk("burst_d3", 32'(got_q[3]), 32'h0000FFEC);

        // Write then read-after-write, then aliased read
        got_q.delete();
        do_req(1'b1, 16'h0020, 16'h1234);
        do_req(1'b0, 16'h0020, 16'h0000);
        wait_idle();
        chk("raw_cnt", got_q.size(), 32'd2);
        chk("raw_data", 32'(got_q[1]), 32'h00001234);
        got_q.delete();
        do_req(1'b0, 16'h0120, 16'h0000);
        wait_idle();
        chk("alias_data", 32'(got_q[0]), 32'h00001234);

        // Drop cyc with two reads outstanding
        do_req(1'b0, 16'h0030, 16'h0000);
        do_req(1'b0, 16'h0031, 16'h0000);
        wb_cyc_i = 1'b0;
        n0 = ack_cnt;
        idle(4);
        chk("flush_no_ack", ack_cnt, n0);
        got_q.delete();
        do_req(1'b0, 16'h0001, 16'h0000);
        wait_idle();
        chk("after_flush_data", 32'(got_q[0]), 32'h0000FFFE);

        // Reset mid-transfer; write under reset is suppressed
        do_req(1'b1, 16'h0050, 16'h55AA);
        wait_idle();
        do_req(1'b0, 16'h0040, 16'h0000);
        rst_i = 1'b1;
        n0 = ack_cnt;
        do_req(1'b0, 16'h0041, 16'h0000);
        do_req(1'b1, 16'h0060, 16'hBEEF);
        idle(2);
        chk("reset_no_ack", ack_cnt, n0);
        chk("reset_ack_low", 32'(wb_ack_o), 32'd0);
        rst_i = 1'b0;
        idle(1);
        got_q.delete();
        do_req(1'b0, 16'h0060, 16'h0000);
        do_req(1'b0, 16'h0050, 16'h0000);
        wait_idle();
        chk("reset_write_dropped", 32'(got_q[0]), 32'h0000FF9F);
        chk("ram_survives_reset", 32'(got_q[1]), 32'h000055AA);

`ifdef WB_MEM_STALL_EN
        // Continuous strobe with pseudo-random stalls
        acc_n = 0; run_len = 0; max_run = 0; stall_n = 0;
        n0 = ack_cnt;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 16'h0080;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (wb_stall_o) begin
                run_len++;
                stall_n++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
                acc_n++;
            end
            @(posedge clk_i);
            #1;
            wb_addr_i = 16'h0080 + 16'(acc_n % 64);
        end
        wb_stb_i = 1'b0;
        wait_idle();
        chk("stall_run_max_le3", 32'(max_run <= 3), 32'd1);
        chk("stall_seen", 32'(stall_n > 0), 32'd1);
        chk("stall_ack_count", ack_cnt - n0, acc_n);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
